ps2_key_scheduler: RTL and testbench
====================================

Name: ps2_key_scheduler

Overview:
- Sits between PS2_Interface and its two consumers: the LCD controller and the processor.
- Decodes raw PS/2 scan-code bytes (E0 extended prefix, F0 break prefix) into key events and buffers them in a FIFO.
- Dispatches each event in order to a processor-readable mailbox.
- Make events are also sent to the LCD write port, with flow control on lcd_busy.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; must be a power of 2, minimum 2.
- BREAK_TO_LCD, 0, when 1, break events are also written to the LCD.
- CW, 4, width of fifo_count, equal to log2(FIFO_DEPTH)+1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_key_pressed  in  1  one-cycle strobe; ps2_key_data is valid in that cycle.
- ps2_key_data  in  8  raw scan-code byte.
- lcd_busy  in  1  LCD controller busy; no write is accepted while it is high.
- lcd_write_en  out  1  one-cycle LCD write strobe.
- lcd_write_data  out  8  scan code to the LCD, valid while lcd_write_en is high.
- cpu_key_rd  in  1  one-cycle pulse; the processor consumes the mailbox.
- cpu_key_valid  out  1  mailbox holds an unread event.
- cpu_key_data  out  10  mailbox contents {ext, brk, code[7:0]}.
- cpu_key_lost  out  1  sticky: an unread mailbox event was overwritten.
- fifo_count  out  CW  current FIFO occupancy.
- fifo_overflow  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - All outputs 0.
  - Decoder in IDLE, dispatcher in D_IDLE, FIFO empty.
  - Reset asserted mid-operation aborts everything; lcd_write_en is 0 from the cycle after reset is sampled.
- Decoder FSM, advances only on ps2_key_pressed:
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - AA, FA, EE, FC → dropped, stay in IDLE.
    - Any other byte → emit {0,0,byte}.
  - EXT:
    - F0 → EXT_BRK.
    - E0 → stay in EXT.
    - Any other byte → emit {1,0,byte}, go to IDLE.
  - BRK:
    - E0 → EXT_BRK.
    - F0 → stay in BRK.
    - Any other byte → emit {0,1,byte}, go to IDLE.
  - EXT_BRK:
    - E0 or F0 → stay in EXT_BRK.
    - Any other byte → emit {1,1,byte}, go to IDLE.
  - Bytes 00 and FF (keyboard overrun) in any state: no event, go to IDLE.
- Emit to FIFO:
  - An event emitted in cycle N is written to the FIFO at the edge ending N; fifo_count reflects it in N+1.
  - If the FIFO is full and no pop occurs that cycle: the event is dropped, fifo_overflow is set, fifo_count stays at FIFO_DEPTH.
  - Push and pop in the same cycle: both happen, count unchanged; a push into a full FIFO succeeds if a pop occurs in that cycle.
- Dispatcher FSM:
  - D_IDLE, FIFO non-empty: pop the head and load it into the mailbox.
    - Then go to D_LCD if the event is a make, or if BREAK_TO_LCD=1.
    - Otherwise stay in D_IDLE; back-to-back pops are allowed, one per cycle.
  - D_LCD:
    - lcd_busy=0: assert lcd_write_en for one cycle with lcd_write_data=code, go to D_WAIT.
    - lcd_busy=1: hold, with lcd_write_en at 0.
  - D_WAIT: exactly one cycle, so the LCD can raise busy, then go to D_IDLE.
  - Minimum spacing between LCD strobes is 3 cycles.
- Mailbox:
  - On load: cpu_key_data ← event and cpu_key_valid ← 1.
  - If cpu_key_valid was already 1 and cpu_key_rd is not asserted in that cycle: set cpu_key_lost.
  - Load and cpu_key_rd in the same cycle: load wins, cpu_key_valid stays 1, cpu_key_lost is not set.
  - cpu_key_rd with no load: clears cpu_key_valid and cpu_key_lost.
  - cpu_key_rd while cpu_key_valid=0: no effect.
- The FIFO pointers wrap modulo FIFO_DEPTH; there is no other wrap behaviour.

Test Plan:
1. Byte 1C alone: mailbox {0,0,1C}, cpu_key_valid=1 by 3 cycles after the strobe; one lcd_write_en with data 1C; fifo_count returns to 0.
2. Bytes E0 F0 75: mailbox {1,1,75} = 10'h375; no lcd_write_en (BREAK_TO_LCD=0). Same sequence with BREAK_TO_LCD=1: one strobe with data 75.
3. lcd_busy held high, 10 make codes sent without cpu_key_rd: fifo_count peaks at 8 (one event held in D_LCD); fifo_overflow=1; cpu_key_lost=1 after further loads; no lcd_write_en until busy drops.
4. cpu_key_rd in the same cycle as a mailbox load: cpu_key_valid stays 1, cpu_key_lost stays 0, data equals the new event.
5. Bytes AA, FA, 00, then 1C with decoder in BRK after F0, then 00, then 1C: no events for AA/FA/00; the final 1C is delivered as a make {0,0,1C}.
6. Reset asserted while in D_LCD with 3 events queued: next cycle all outputs 0, fifo_count=0, and no stale strobe after reset is released.

Source files
------------

// File: rtl/ps2_key_scheduler.sv
// PS/2 scan-code decoder feeding an event FIFO, drained in order into a CPU mailbox
// and, for make events (optionally breaks too), into a flow-controlled LCD write port.
module ps2_key_scheduler #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter bit          BREAK_TO_LCD = 1'b0,
    parameter int unsigned CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ps2_key_pressed,
    input  logic [7:0]    ps2_key_data,
    input  logic          lcd_busy,
    output logic          lcd_write_en,
    output logic [7:0]    lcd_write_data,
    input  logic          cpu_key_rd,
    output logic          cpu_key_valid,
    output logic [9:0]    cpu_key_data,
    output logic          cpu_key_lost,
    output logic [CW-1:0] fifo_count,
    output logic          fifo_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} dec_e;
    typedef enum logic [1:0] {DIdle, DLcd, DWait} disp_e;

    dec_e          dec_q, dec_d;
    disp_e         disp_q, disp_d;
    logic          emit;
    logic [9:0]    ev_data;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full, pop, push_ok;
    logic [9:0]    head;
    logic          valid_q, valid_d, lost_q, lost_d;
    logic [9:0]    key_q, key_d;
    logic          lcd_we_q, lcd_we_d;
    logic [7:0]    lcd_data_q, lcd_data_d;

    always_comb begin
        dec_d   = dec_q;
        emit    = 1'b0;
        ev_data = {2'b00, ps2_key_data};
        if (ps2_key_pressed) begin
            // Overrun bytes resynchronise the decoder from any state.
            if (ps2_key_data == 8'h00 || ps2_key_data == 8'hFF) begin
                dec_d = StIdle;
            end else begin
                unique case (dec_q)
                    StIdle: begin
                        if (ps2_key_data == 8'hE0) dec_d = StExt;
                        else if (ps2_key_data == 8'hF0) dec_d = StBrk;
                        else if (ps2_key_data != 8'hAA && ps2_key_data != 8'hFA &&
                                 ps2_key_data != 8'hEE && ps2_key_data != 8'hFC) begin
                            emit = 1'b1;
                        end
                    end
                    StExt: begin
                        if (ps2_key_data == 8'hF0) dec_d = StExtBrk;
                        else if (ps2_key_data != 8'hE0) begin
                            emit    = 1'b1;
                            ev_data = {2'b10, ps2_key_data};
                            dec_d   = StIdle;
                        end
                    end
                    StBrk: begin
                        if (ps2_key_data == 8'hE0) dec_d = StExtBrk;
                        else if (ps2_key_data != 8'hF0) begin
                            emit    = 1'b1;
                            ev_data = {2'b01, ps2_key_data};
                            dec_d   = StIdle;
                        end
                    end
                    default: begin
                        if (ps2_key_data != 8'hE0 && ps2_key_data != 8'hF0) begin
                            emit    = 1'b1;
                            ev_data = {2'b11, ps2_key_data};
                            dec_d   = StIdle;
                        end
                    end
                endcase
            end
        end
    end

    assign head    = mem_q[rd_ptr_q];
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = (disp_q == DIdle) && (count_q != '0);
    assign push_ok = emit && (!full || pop);

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        ovf_d    = ovf_q | (emit & full & ~pop);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        disp_d     = disp_q;
        lcd_we_d   = 1'b0;
        lcd_data_d = lcd_data_q;
        valid_d    = valid_q;
        lost_d     = lost_q;
        key_d      = key_q;
        unique case (disp_q)
            DIdle: begin
                if (pop) begin
                    key_d   = head;
                    valid_d = 1'b1;
                    if (valid_q && !cpu_key_rd) lost_d = 1'b1;
                    if (!head[8] || BREAK_TO_LCD) disp_d = DLcd;
                end
            end
            DLcd: begin
                if (!lcd_busy) begin
                    lcd_we_d   = 1'b1;
                    lcd_data_d = key_q[7:0];
                    disp_d     = DWait;
                end
            end
            default: disp_d = DIdle;
        endcase
        if (!pop && cpu_key_rd && valid_q) begin
            valid_d = 1'b0;
            lost_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dec_q      <= StIdle;
            disp_q     <= DIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            lost_q     <= 1'b0;
            key_q      <= '0;
            lcd_we_q   <= 1'b0;
            lcd_data_q <= '0;
        end else begin
            dec_q      <= dec_d;
            disp_q     <= disp_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            lost_q     <= lost_d;
            key_q      <= key_d;
            lcd_we_q   <= lcd_we_d;
            lcd_data_q <= lcd_data_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= ev_data;
    end

    assign lcd_write_en   = lcd_we_q;
    assign lcd_write_data = lcd_data_q;
    assign cpu_key_valid  = valid_q;
    assign cpu_key_data   = key_q;
    assign cpu_key_lost   = lost_q;
    assign fifo_count     = count_q;
    assign fifo_overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Directed bench for ps2_key_scheduler: a make-only-to-LCD instance and a
// break-to-LCD instance share stimulus.
module tb_ps2_key_scheduler;

    logic       clock = 1'b0;
    logic       reset, ps2_key_pressed, lcd_busy, cpu_key_rd;
    logic [7:0] ps2_key_data;

    logic       we0, valid0, lost0, ovf0;
    logic [7:0] ld0;
    logic [9:0] key0;
    logic [3:0] count0;
    logic       we1, valid1, lost1, ovf1;
    logic [7:0] ld1;
    logic [9:0] key1;
    logic [3:0] count1;

    ps2_key_scheduler #(.FIFO_DEPTH(8), .BREAK_TO_LCD(1'b0), .CW(4)) u0 (
        .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed),
        .ps2_key_data(ps2_key_data), .lcd_busy(lcd_busy), .lcd_write_en(we0),
        .lcd_write_data(ld0), .cpu_key_rd(cpu_key_rd), .cpu_key_valid(valid0),
        .cpu_key_data(key0), .cpu_key_lost(lost0), .fifo_count(count0),
        .fifo_overflow(ovf0)
    );

    ps2_key_scheduler #(.FIFO_DEPTH(8), .BREAK_TO_LCD(1'b1), .CW(4)) u1 (
        .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed),
        .ps2_key_data(ps2_key_data), .lcd_busy(lcd_busy), .lcd_write_en(we1),
        .lcd_write_data(ld1), .cpu_key_rd(cpu_key_rd), .cpu_key_valid(valid1),
        .cpu_key_data(key1), .cpu_key_lost(lost1), .fifo_count(count1),
        .fifo_overflow(ovf1)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    int cnt0 = 0, cnt1 = 0, exp0 = 0, exp1 = 0;
    logic [7:0] last0 = '0, last1 = '0;
    int cyc = 0, last_cyc = -1000, min_gap = 1000;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (we0) begin
            cnt0  = cnt0 + 1;
            last0 = ld0;
            if (cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
            last_cyc = cyc;
        end
        if (we1) begin
            cnt1  = cnt1 + 1;
            last1 = ld1;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       ev;
        logic [9:0] key;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ps2_key_data    = b;
        ps2_key_pressed = 1'b1;
        step();
        ps2_key_pressed = 1'b0;
    endtask

    task automatic read_pulse();
        cpu_key_rd = 1'b1;
        step();
        cpu_key_rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ps2_key_pressed = 1'b0; ps2_key_data = '0;
        lcd_busy = 1'b0; cpu_key_rd = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst we", we0, 0);
        chk("rst lcd data", ld0, 0);
        chk("rst valid", valid0, 0);
        chk("rst key", key0, 0);
        chk("rst lost", lost0, 0);
        chk("rst count", count0, 0);
        chk("rst ovf", ovf0, 0);

        // Single make: latency through FIFO into mailbox.
        send(8'h1C);
        chk("t1 count after push", count0, 1);
        chk("t1 valid early", valid0, 0);
        step();
        chk("t1 valid", valid0, 1);
        chk("t1 key", key0, 10'h01C);
        chk("t1 count drained", count0, 0);
        repeat (3) step();
        exp0++; exp1++;
        chk("t1 lcd count", cnt0, exp0);
        chk("t1 lcd data", last0, 8'h1C);
        read_pulse();
        chk("t1 valid cleared", valid0, 0);

        vecs.push_back('{8'hE0, 1'b0, 10'h000});
        vecs.push_back('{8'hF0, 1'b0, 10'h000});
        vecs.push_back('{8'h75, 1'b1, 10'h375});
        vecs.push_back('{8'hAA, 1'b0, 10'h000});
        vecs.push_back('{8'hFA, 1'b0, 10'h000});
        vecs.push_back('{8'hF0, 1'b0, 10'h000});
        vecs.push_back('{8'h00, 1'b0, 10'h000});
        vecs.push_back('{8'h1C, 1'b1, 10'h01C});
        vecs.push_back('{8'hE0, 1'b0, 10'h000});
        vecs.push_back('{8'h74, 1'b1, 10'h274});
        vecs.push_back('{8'hF0, 1'b0, 10'h000});
        vecs.push_back('{8'h1C, 1'b1, 10'h11C});
        vecs.push_back('{8'hEE, 1'b0, 10'h000});
        vecs.push_back('{8'hFF, 1'b0, 10'h000});
        vecs.push_back('{8'hE0, 1'b0, 10'h000});
        vecs.push_back('{8'hE0, 1'b0, 10'h000});
        vecs.push_back('{8'hF0, 1'b0, 10'h000});
        vecs.push_back('{8'hF0, 1'b0, 10'h000});
        vecs.push_back('{8'h6B, 1'b1, 10'h36B});
        vecs.push_back('{8'hF0, 1'b0, 10'h000});
        vecs.push_back('{8'hE0, 1'b0, 10'h000});
        vecs.push_back('{8'h70, 1'b1, 10'h370});
        vecs.push_back('{8'hE0, 1'b0, 10'h000});
        vecs.push_back('{8'h00, 1'b0, 10'h000});
        vecs.push_back('{8'h1C, 1'b1, 10'h01C});

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].data);
            repeat (4) step();
            if (vecs[i].ev) begin
                if (!vecs[i].key[8]) exp0++;
                exp1++;
            end
            chk($sformatf("vec%0d valid", i), valid0, vecs[i].ev);
            chk($sformatf("vec%0d count", i), count0, 0);
            chk($sformatf("vec%0d lcd0 n", i), cnt0, exp0);
            chk($sformatf("vec%0d lcd1 n", i), cnt1, exp1);
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d key", i), key0, vecs[i].key);
                chk($sformatf("vec%0d key1", i), key1, vecs[i].key);
                chk($sformatf("vec%0d lcd1 data", i), last1, vecs[i].key[7:0]);
            end
            read_pulse();
        end

        // Read in the same cycle as a load, then an unread overwrite.
        send(8'h15);
        repeat (4) step();
        chk("t4 first valid", valid0, 1);
        send(8'h1C);
        cpu_key_rd = 1'b1;
        step();
        cpu_key_rd = 1'b0;
        chk("t4 valid kept", valid0, 1);
        chk("t4 lost clear", lost0, 0);
        chk("t4 key new", key0, 10'h01C);
        repeat (3) step();
        send(8'h24);
        repeat (4) step();
        chk("t4 lost set", lost0, 1);
        chk("t4 key 24", key0, 10'h024);
        read_pulse();
        chk("t4 rd valid", valid0, 0);
        chk("t4 rd lost", lost0, 0);
        exp0 += 3; exp1 += 3;
        chk("t4 lcd n", cnt0, exp0);

        // LCD stalled, FIFO overfills.
        lcd_busy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ps2_key_data    = 8'(8'h15 + k);
            ps2_key_pressed = 1'b1;
            step();
        end
        ps2_key_pressed = 1'b0;
        step(); step();
        chk("t3 count full", count0, 8);
        chk("t3 overflow", ovf0, 1);
        chk("t3 mailbox", key0, 10'h015);
        chk("t3 lost early", lost0, 0);
        repeat (10) step();
        chk("t3 no strobe busy", cnt0, exp0);
        last_cyc = -1000;
        min_gap  = 1000;
        lcd_busy = 1'b0;
        repeat (40) step();
        exp0 += 9; exp1 += 9;
        chk("t3 lcd n", cnt0, exp0);
        chk("t3 drained", count0, 0);
        chk("t3 lost", lost0, 1);
        chk("t3 last key", key0, 10'h01D);
        chk("t3 last lcd", last0, 8'h1D);
        chk("t3 min gap", min_gap, 3);
        chk("t3 ovf sticky", ovf0, 1);

        // Reset while stalled in D_LCD with three events queued.
        lcd_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ps2_key_data    = 8'(8'h30 + k);
            ps2_key_pressed = 1'b1;
            step();
        end
        ps2_key_pressed = 1'b0;
        step(); step();
        chk("t6 queued", count0, 3);
        reset = 1'b1;
        step();
        chk("t6 we", we0, 0);
        chk("t6 we1", we1, 0);
        chk("t6 lcd data", ld0, 0);
        chk("t6 valid", valid0, 0);
        chk("t6 key", key0, 0);
        chk("t6 lost", lost0, 0);
        chk("t6 count", count0, 0);
        chk("t6 ovf", ovf0, 0);
        reset    = 1'b0;
        lcd_busy = 1'b0;
        repeat (10) step();
        chk("t6 no stale strobe", cnt0, exp0);
        chk("t6 no stale strobe1", cnt1, exp1);
        chk("t6 still empty", valid0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
